// File: rtl/vec_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// vec_ctrl_sequencer
//
// ID-stage vector control sequencer. Decodes the 4-bit vector ISA and, for
// SUMFV/MULFV, walks the element indices 0..vlen-1. Each element gets one
// memory read enable, then one write enable PIPE_LAT non-stalled cycles later,
// which matches the latency of the vector ALU pipeline.
//
// Opcodes: 0 INCRI, 1 INCRJ, 2 SETN, 3 SUMFV, 4 MULFV, 5 NOP, others = NOP.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   instr_valid      opcode valid; accepted when instr_valid && ready
//   opcode[OPW]      instruction opcode
//   setn_val[CNT_W]  SETN immediate (clamped to VLEN_MAX)
//   stall_in         downstream stall, freezes RUN/DRAIN, ignored in IDLE
//   ready            high in IDLE
//   vec_alu_op       0 = add (SUMFV), 1 = mul (MULFV); holds between ops
//   r_mem_1/r_mem_2  read enables for MULFV / SUMFV
//   w_mem_2/w_mem_3  write enables for MULFV / SUMFV
//   r_idx/w_idx      element index accompanying the read / write enable
//   idx_i/idx_j      loop registers i and j
//   vlen             current vector length n
//   busy             high in RUN or DRAIN
//   done             one-cycle pulse after the last write of a vector op
//   perf_busy_cnt    cycles spent busy (saturating)
//   perf_stall_cnt   cycles spent busy and stalled (saturating)
//
// Build option: define VEC_CTRL_PERF_CNT_EN to build the two performance
// counters; otherwise the perf ports are tied to zero.
//
// The memory enables are the only outputs not taken straight from a flop:
// they are qualified by stall_in in the same cycle so a stalled cycle can
// never issue an access that the frozen counters would then repeat.
// -----------------------------------------------------------------------------
module vec_ctrl_sequencer #(
    parameter int OPW      = 4,
    parameter int VLEN_MAX = 16,
    parameter int CNT_W    = $clog2(VLEN_MAX + 1),
    parameter int IDX_W    = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [OPW-1:0]   opcode,
    input  logic [CNT_W-1:0] setn_val,
    input  logic             stall_in,
    output logic             ready,
    output logic             vec_alu_op,
    output logic             r_mem_1,
    output logic             r_mem_2,
    output logic             w_mem_2,
    output logic             w_mem_3,
    output logic [CNT_W-1:0] r_idx,
    output logic [CNT_W-1:0] w_idx,
    output logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] idx_j,
    output logic [CNT_W-1:0] vlen,
    output logic             busy,
    output logic             done,
    output logic [31:0]      perf_busy_cnt,
    output logic [31:0]      perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [OPW-1:0]   OP_INCRI   = OPW'(0);
    localparam logic [OPW-1:0]   OP_INCRJ   = OPW'(1);
    localparam logic [OPW-1:0]   OP_SETN    = OPW'(2);
    localparam logic [OPW-1:0]   OP_SUMFV   = OPW'(3);
    localparam logic [OPW-1:0]   OP_MULFV   = OPW'(4);
    localparam logic [CNT_W-1:0] VLEN_MAX_C = CNT_W'(VLEN_MAX);

    // Registered state
    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   vlen_q,   vlen_d;
    logic [IDX_W-1:0]   idx_i_q,  idx_i_d;
    logic [IDX_W-1:0]   idx_j_q,  idx_j_d;
    logic               op_mul_q, op_mul_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               done_q,   done_d;
    // Write-side pipeline: one valid/index pair per ALU stage.
    logic               sr_vld_q [PIPE_LAT];
    logic               sr_vld_d [PIPE_LAT];
    logic [CNT_W-1:0]   sr_idx_q [PIPE_LAT];
    logic [CNT_W-1:0]   sr_idx_d [PIPE_LAT];

    // Per-cycle qualifiers
    logic active;
    logic advance;
    logic rd_fire;
    logic wr_fire;
    logic last_rd;
    logic last_wr;

    assign active  = (state_q != S_IDLE);
    assign advance = active && !stall_in;
    assign rd_fire = (state_q == S_RUN) && !stall_in;
    assign wr_fire = advance && sr_vld_q[PIPE_LAT-1];
    // vlen cannot change while busy (SETN is only accepted in IDLE), so the
    // last element is simply index vlen-1 on either side of the pipeline.
    assign last_rd = rd_fire && (rd_cnt_q == vlen_q - CNT_W'(1));
    assign last_wr = wr_fire && (sr_idx_q[PIPE_LAT-1] == vlen_q - CNT_W'(1));

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case statements can leave one unassigned and infer a latch.
        state_d  = state_q;
        vlen_d   = vlen_q;
        idx_i_d  = idx_i_q;
        idx_j_d  = idx_j_q;
        op_mul_d = op_mul_q;
        rd_cnt_d = rd_cnt_q;
        done_d   = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            sr_vld_d[i] = sr_vld_q[i];
            sr_idx_d[i] = sr_idx_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    case (opcode)
                        OP_INCRI: idx_i_d = idx_i_q + IDX_W'(1);
                        OP_INCRJ: idx_j_d = idx_j_q + IDX_W'(1);
                        OP_SETN:  vlen_d  = (setn_val > VLEN_MAX_C) ? VLEN_MAX_C : setn_val;
                        OP_SUMFV, OP_MULFV: begin
                            op_mul_d = (opcode == OP_MULFV);
                            rd_cnt_d = '0;
                            for (int i = 0; i < PIPE_LAT; i++) begin
                                sr_vld_d[i] = 1'b0;
                                sr_idx_d[i] = '0;
                            end
                            // An empty vector completes without ever leaving IDLE.
                            if (vlen_q == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        default: ; // NOP and unknown opcodes hold everything
                    endcase
                end
            end

            S_RUN: begin
                if (rd_fire) begin
                    if (last_rd) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (last_wr) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // The write pipeline only moves on non-stalled busy cycles, so write k
        // lands exactly PIPE_LAT advancing cycles after read k.
        if (advance) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                sr_vld_d[i] = sr_vld_q[i-1];
                sr_idx_d[i] = sr_idx_q[i-1];
            end
            sr_vld_d[0] = rd_fire;
            sr_idx_d[0] = rd_cnt_q;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vlen_q   <= '0;
            idx_i_q  <= '0;
            idx_j_q  <= '0;
            op_mul_q <= 1'b0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
            // NOTE: the index pipeline is reset too, even though only its
            // valid bits matter for control, so w_idx is defined out of reset.
            for (int i = 0; i < PIPE_LAT; i++) begin
                sr_vld_q[i] <= 1'b0;
                sr_idx_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge regardless of statement order.
            state_q  <= state_d;
            vlen_q   <= vlen_d;
            idx_i_q  <= idx_i_d;
            idx_j_q  <= idx_j_d;
            op_mul_q <= op_mul_d;
            rd_cnt_q <= rd_cnt_d;
            done_q   <= done_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                sr_vld_q[i] <= sr_vld_d[i];
                sr_idx_q[i] <= sr_idx_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready      = (state_q == S_IDLE);
    assign busy       = active;
    assign done       = done_q;
    assign vec_alu_op = op_mul_q;
    assign vlen       = vlen_q;
    assign idx_i      = idx_i_q;
    assign idx_j      = idx_j_q;
    assign r_idx      = rd_cnt_q;
    assign w_idx      = sr_idx_q[PIPE_LAT-1];

    assign r_mem_1 = rd_fire &&  op_mul_q;
    assign r_mem_2 = rd_fire && !op_mul_q;
    assign w_mem_2 = wr_fire &&  op_mul_q;
    assign w_mem_3 = wr_fire && !op_mul_q;

`ifdef VEC_CTRL_PERF_CNT_EN
    logic [31:0] busy_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (active && (busy_cnt_q != '1)) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
            if (active && stall_in && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_busy_cnt  = busy_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_busy_cnt  = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
